// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer family.
// Defaults assume a 100 MHz system clock.
package debounce_pkg;

  localparam int CLK_HZ  = 100_000_000;
  localparam int DEB_1MS = CLK_HZ / 1000;
  localparam int HOLD_1S = CLK_HZ;

  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
    logic hold;
  } ch_evt_t;

  // Bits needed to hold any value in 0..maxVal.
  function automatic int widthFor(input longint maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/multi_button_debouncer_if.sv
// Button-side bundle: raw inputs toward the debouncer, debounced level and
// event strobes back to the control logic.
interface multi_button_debouncer_if #(
  parameter int N_CH = 4
) ();

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_hold;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_hold
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_hold
  );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, saturating up/down integrator,
// hysteresis level, press/release strobes and a one-shot long-press strobe.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int THRESH_ON   = DEB_1MS,
  parameter int THRESH_OFF  = DEB_1MS / 2,
  parameter int HOLD_CYCLES = HOLD_1S,
  parameter int HOLD_W      = widthFor(HOLD_1S)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_btn,
  output ch_evt_t o_evt
);

  localparam logic [CNT_W-1:0]  ON_LIM   = CNT_W'(THRESH_ON);
  localparam logic [CNT_W-1:0]  OFF_LIM  = CNT_W'(THRESH_OFF);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

  logic              r_ff1;
  logic              r_ff2;
  logic [CNT_W-1:0]  r_count;
  logic              r_level;
  logic              r_press;
  logic              r_rel;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_hold;

  logic w_cntMax;
  logic w_cntMin;
  logic w_rise;
  logic w_fall;
  logic w_holdHit;

  assign w_cntMax  = &r_count;
  assign w_cntMin  = ~|r_count;
  assign w_rise    = !r_level && (r_count > ON_LIM);
  assign w_fall    = r_level && (r_count < OFF_LIM);
  assign w_holdHit = r_level && (r_holdCnt == HOLD_PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
    end else begin
      r_ff1 <= i_btn;
      r_ff2 <= r_ff1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_ff2 && !w_cntMax) begin
      r_count <= r_count + 1'b1;
    end else if (!r_ff2 && !w_cntMin) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Between the two thresholds the level simply holds, giving hysteresis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_press <= w_rise;
      r_rel   <= w_fall;
      if (w_rise) begin
        r_level <= 1'b1;
      end else if (w_fall) begin
        r_level <= 1'b0;
      end
    end
  end

  // Saturating at HOLD_CYCLES makes the hold strobe a one-shot per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdCnt <= '0;
      r_hold    <= 1'b0;
    end else begin
      r_hold <= w_holdHit;
      if (!r_level) begin
        r_holdCnt <= '0;
      end else if (r_holdCnt != HOLD_LIM) begin
        r_holdCnt <= r_holdCnt + 1'b1;
      end
    end
  end

  assign o_evt = '{lvl: r_level, press: r_press, rel: r_rel, hold: r_hold};

endmodule

// File: rtl/multi_button_debouncer.sv
// N independent debounce channels behind a single button interface, with
// elaboration-time sanity checks on the threshold and counter parameters.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 20,
  parameter int THRESH_ON   = DEB_1MS,
  parameter int THRESH_OFF  = DEB_1MS / 2,
  parameter int HOLD_CYCLES = HOLD_1S,
  parameter int HOLD_W      = widthFor(HOLD_1S)
) (
  input logic                    clk,
  input logic                    rst,
  multi_button_debouncer_if.slave bus
);

  if (N_CH < 1) begin : g_errNch
    $fatal(1, "N_CH must be at least 1");
  end
  if (longint'(THRESH_OFF) > longint'(THRESH_ON) + 1) begin : g_errOff
    $fatal(1, "THRESH_OFF must not exceed THRESH_ON+1");
  end
  if (longint'(THRESH_ON) >= (longint'(1) << CNT_W) - 1) begin : g_errOn
    $fatal(1, "THRESH_ON must be below the integrator saturation value");
  end
  if (HOLD_CYCLES < 1) begin : g_errHoldMin
    $fatal(1, "HOLD_CYCLES must be at least 1");
  end
  if (longint'(HOLD_CYCLES) >= (longint'(1) << HOLD_W)) begin : g_errHoldW
    $fatal(1, "HOLD_W too narrow for HOLD_CYCLES");
  end

  ch_evt_t         w_evt [N_CH];
  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_press;
  logic [N_CH-1:0] w_rel;
  logic [N_CH-1:0] w_hold;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .THRESH_ON  (THRESH_ON),
      .THRESH_OFF (THRESH_OFF),
      .HOLD_CYCLES(HOLD_CYCLES),
      .HOLD_W     (HOLD_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .i_btn(bus.btn_in[g]),
      .o_evt(w_evt[g])
    );
  end

  always_comb begin
    w_level = '0;
    w_press = '0;
    w_rel   = '0;
    w_hold  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_level[i] = w_evt[i].lvl;
      w_press[i] = w_evt[i].press;
      w_rel[i]   = w_evt[i].rel;
      w_hold[i]  = w_evt[i].hold;
    end
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_rel;
  assign bus.btn_hold    = w_hold;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: fixed vectors, directed corner cases and
// random button activity compared against an integer reference model.
module tb_multi_button_debouncer;

  localparam int N_CH    = 2;
  localparam int CNT_W   = 8;
  localparam int TH_ON   = 10;
  localparam int TH_OFF  = 5;
  localparam int HOLD    = 20;
  localparam int HOLD_W  = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int N_VEC   = 10;

  typedef struct {
    logic [N_CH-1:0] btn;
    int              cycles;
    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] hold;
    string           name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Model state: integer integrator, input history, length of the current high run.
  int              mCount [N_CH];
  bit              mIn1   [N_CH];
  bit              mIn2   [N_CH];
  int              mRun   [N_CH];
  logic [N_CH-1:0] mLevel;
  logic [N_CH-1:0] mPress;
  logic [N_CH-1:0] mRel;
  logic [N_CH-1:0] mHold;

  vec_t vecs [N_VEC];
  int   runLeft [N_CH];

  multi_button_debouncer_if #(.N_CH(N_CH)) bus ();

  multi_button_debouncer #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .THRESH_ON  (TH_ON),
    .THRESH_OFF (TH_OFF),
    .HOLD_CYCLES(HOLD),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int c = 0; c < N_CH; c++) begin
      mCount[c] = 0;
      mIn1[c]   = 1'b0;
      mIn2[c]   = 1'b0;
      mRun[c]   = 0;
    end
    mLevel = '0;
    mPress = '0;
    mRel   = '0;
    mHold  = '0;
  endfunction

  // Hold fires once the level has been high for exactly HOLD consecutive cycles.
  function automatic void modelEdge(input logic [N_CH-1:0] sampled);
    bit was;
    bit now;
    for (int c = 0; c < N_CH; c++) begin
      was = mLevel[c];
      now = was;
      if (!was && mCount[c] > TH_ON) now = 1'b1;
      if (was && mCount[c] < TH_OFF) now = 1'b0;
      mPress[c] = now && !was;
      mRel[c]   = was && !now;
      mRun[c]   = was ? mRun[c] + 1 : 0;
      mHold[c]  = (mRun[c] == HOLD);
      if (mIn2[c]) mCount[c] = (mCount[c] < CNT_MAX) ? mCount[c] + 1 : CNT_MAX;
      else         mCount[c] = (mCount[c] > 0) ? mCount[c] - 1 : 0;
      mIn2[c]   = mIn1[c];
      mIn1[c]   = sampled[c];
      mLevel[c] = now;
    end
  endfunction

  function automatic logic [7:0] outs();
    return {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold};
  endfunction

  task automatic checkBits(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    checkBits(name, outs(), {mLevel, mPress, mRel, mHold});
  endtask

  task automatic tick();
    logic [N_CH-1:0] sampled;
    sampled = bus.btn_in;
    @(posedge clk);
    if (!rst) modelEdge(sampled);
    #1;
    checkOutput("model");
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] btn, input int n);
    bus.btn_in = btn;
    repeat (n) tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    bus.btn_in = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic checkRelease14(input string tag);
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 13) checkBits({tag, "Edge13"}, outs(), 8'b00_00_00_00);
      if (e == 14) checkBits({tag, "Edge14"}, outs(), 8'b11_11_00_00);
      if (e == 15) checkBits({tag, "Edge15"}, outs(), 8'b11_00_00_00);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b01,  13, 2'b00, 2'b00, 2'b00, 2'b00, "t3Edge13"};
    vecs[1] = '{2'b01,   1, 2'b01, 2'b01, 2'b00, 2'b00, "t3PressEdge14"};
    vecs[2] = '{2'b01,   1, 2'b01, 2'b00, 2'b00, 2'b00, "t3Edge15"};
    vecs[3] = '{2'b01,  18, 2'b01, 2'b00, 2'b00, 2'b00, "t3Edge33"};
    vecs[4] = '{2'b01,   1, 2'b01, 2'b00, 2'b00, 2'b01, "t3HoldEdge34"};
    vecs[5] = '{2'b01,   1, 2'b01, 2'b00, 2'b00, 2'b00, "t3Edge35"};
    vecs[6] = '{2'b01, 265, 2'b01, 2'b00, 2'b00, 2'b00, "t3Edge300"};
    vecs[7] = '{2'b00, 253, 2'b01, 2'b00, 2'b00, 2'b00, "t4Drop253"};
    vecs[8] = '{2'b00,   1, 2'b00, 2'b00, 2'b01, 2'b00, "t4ReleaseDrop254"};
    vecs[9] = '{2'b00,   1, 2'b00, 2'b00, 2'b00, 2'b00, "t4Drop255"};

    // Reset with buttons held, then both channels press together.
    rst = 1'b1;
    bus.btn_in = 2'b11;
    modelReset();
    repeat (3) begin
      tick();
      checkBits("t1RstOut", outs(), 8'h00);
    end
    rst = 1'b0;
    checkRelease14("t1");

    // Bounce on ch0 that never accumulates enough to assert.
    doReset();
    for (int i = 0; i < 60; i++) begin
      bus.btn_in = {1'b0, ((i / 3) % 2 == 0)};
      tick();
      checkBits("t2Bounce", {4'b0, bus.btn_level[0], bus.btn_press[0], bus.btn_release[0], bus.btn_hold[0]}, 8'h00);
    end

    // Long press, hold strobe, saturation and release timing.
    doReset();
    for (int i = 0; i < N_VEC; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].cycles);
      checkBits(vecs[i].name, outs(), {vecs[i].lvl, vecs[i].press, vecs[i].rel, vecs[i].hold});
    end

    // Keep the count inside the band (5..10) from both sides of the hysteresis.
    doReset();
    for (int i = 0; i < 100; i++) begin
      bus.btn_in = {1'b0, (mCount[0] <= 7)};
      tick();
      checkBits("t5BandLow", {6'b0, bus.btn_level[0], bus.btn_press[0]}, 8'h00);
    end
    for (int k = 0; k < 30 && !mLevel[0]; k++) begin
      bus.btn_in = 2'b01;
      tick();
    end
    checkBits("t5Pressed", {7'b0, bus.btn_level[0]}, 8'h01);
    for (int i = 0; i < 100; i++) begin
      bus.btn_in = {1'b0, (mCount[0] <= 7)};
      tick();
      checkBits("t5BandHigh", {6'b0, bus.btn_level[0], bus.btn_release[0]}, 8'b10);
    end

    // Asynchronous reset mid-cycle with ch0 high and ch1 mid-integration.
    doReset();
    applyStimulus(2'b01, 20);
    applyStimulus(2'b11, 9);
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checkBits("t6AsyncRst", outs(), 8'h00);
    repeat (2) begin
      tick();
      checkBits("t6NoRelease", {6'b0, bus.btn_release}, 8'h00);
    end
    rst = 1'b0;
    checkRelease14("t6");

    // Random press/bounce activity on both channels.
    doReset();
    for (int c = 0; c < N_CH; c++) runLeft[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (runLeft[c] == 0) begin
          bus.btn_in[c] = ~bus.btn_in[c];
          runLeft[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                    : int'($urandom_range(12, 60));
        end
        runLeft[c]--;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
Parametrised N-channel push-button debouncer. It uses a saturating up/down integrator per channel, with separate assert and deassert thresholds (hysteresis). Each channel provides a debounced level, one-cycle press/release strobes and a one-shot long-press strobe. It sits between the board buttons and the transmit/control logic, and replaces single-channel, single-threshold debouncing.

Parameters:
N_CH, 4, number of independent button channels
CNT_W, 20, integrator width; counter saturates at 2^CNT_W-1
THRESH_ON, 100000, level asserts when count > THRESH_ON
THRESH_OFF, 50000, level deasserts when count < THRESH_OFF
HOLD_CYCLES, 100000000, cycles level must stay high before btn_hold fires (1 s at 100 MHz)
HOLD_W, 27, hold counter width; must satisfy 2^HOLD_W > HOLD_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_in  input  N_CH  raw asynchronous button inputs
btn_level  output  N_CH  debounced level per channel
btn_press  output  N_CH  one-cycle strobe on level 0->1
btn_release  output  N_CH  one-cycle strobe on level 1->0
btn_hold  output  N_CH  one-cycle strobe when a press has lasted HOLD_CYCLES

Behaviour:
- Reset:
  - rst asynchronously clears all state: sync flops, count, level, hold counter and all outputs (0).
  - No strobes fire during reset or as a side-effect of reset; a level forced 1->0 by rst produces no btn_release.
- Channels: fully independent; simultaneous events on different channels are all reported in the same cycle.
- Synchroniser: 2-flop chain per channel (ff1 <= btn_in, ff2 <= ff1).
- Integrator:
  - ff2=1: count+1 unless count = all-ones (saturate high).
  - ff2=0: count-1 unless count = 0 (saturate low).
- Level (registered from the registered count):
  - level=0 and count > THRESH_ON -> level<=1.
  - level=1 and count < THRESH_OFF -> level<=0.
  - Otherwise level holds; this is the hysteresis band.
  - THRESH_OFF = THRESH_ON+1 degenerates to the single-threshold behaviour.
- Strobes:
  - btn_press and btn_release are registered and high exactly in the first cycle the new level is visible.
  - Never both high on the same channel.
- Latency: from the first clk edge sampling btn_in=1 with count=0, btn_level/btn_press rise at edge THRESH_ON+4 (2 sync + THRESH_ON+1 increments + 1 level register).
- Long press:
  - hold counter increments each cycle level=1 and saturates at HOLD_CYCLES.
  - btn_hold is high for the single cycle in which the counter becomes HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles after btn_press.
  - Fires at most once per press; the hold counter clears when level=0.
  - A release before HOLD_CYCLES produces no btn_hold.
- Elaboration-time checks, which must fail elaboration if violated:
  - THRESH_OFF <= THRESH_ON+1
  - THRESH_ON < 2^CNT_W-1
  - HOLD_CYCLES >= 1
  - HOLD_CYCLES < 2^HOLD_W
- Bounce: any input pattern whose net count stays within [0, THRESH_ON] from an idle state produces no output activity.

Decomposition:
- Shared package debounce_pkg holds:
  - CLK_HZ = 100000000
  - DEB_1MS = 100000
  - HOLD_1S = 100000000
  - a $clog2-based width helper, used for defaults across the design.
- Sub-module debounce_channel contains one channel's synchroniser, integrator, hysteresis level, edge strobes and hold counter, with the same parameters minus N_CH.
- multi_button_debouncer is a generate loop of N_CH debounce_channel instances plus parameter checks.

Test Plan:
Bench parameters: N_CH=2, CNT_W=8, THRESH_ON=10, THRESH_OFF=5, HOLD_CYCLES=20, HOLD_W=6.
1. rst=1 with btn_in=2'b11 -> all outputs 0. Release rst, keep btn_in=11 -> btn_level=11 and btn_press=11 (single cycle) at edge 14 after rst deassert.
2. ch0 toggled every 3 cycles for 60 cycles from idle -> count never exceeds 3, btn_level[0]=0, no press/release/hold strobes.
3. ch0 held high 300 cycles -> btn_press[0] at edge 14, btn_hold[0] exactly once at edge 34, no further btn_hold, count saturates at 255.
4. From (3), drop ch0 -> btn_level[0] falls with one-cycle btn_release[0] at edge 254 after the drop (count 255->4), hold counter cleared.
5. Hysteresis: after press, drive ch0 with duty pattern keeping count oscillating 6..9 for 100 cycles -> btn_level[0] stays 1, no btn_release. Same pattern from level=0 -> level stays 0, no btn_press.
6. ch0 level=1, ch1 pressing mid-integration (count≈7); assert rst asynchronously between clk edges -> all outputs 0 immediately, no btn_release strobe. On deassert with both inputs high, both presses re-detected at edge 14, same cycle.
